pll_lock_sequencer: RTL

- Sequences the audio/RTC PLL (74.25 MHz refclk in; 32.768 MHz and 12.288 MHz outputs, one 12.288 MHz output phase-shifted) from reset to a stable running state.
- Drives the PLL reset and watches its asynchronous locked output.
- Releases the core reset only after lock has held stable for a programmed time.
- On timeout, retries the PLL reset a bounded number of times. Recovers automatically from lock loss.
- Runs in the refclk domain, alongside the PLL wrapper.

---
 rtl/pll_lock_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//
// Brings the audio/RTC PLL from reset to a stable running state and keeps it there.
// The PLL reset is pulsed, lock is awaited within a bounded window, and lock must then hold
// continuously for a programmed time before the core reset is released. Lock timeouts retry
// the PLL reset a bounded number of times before parking in a failed state. Lock loss while
// running restarts the whole sequence. Runs entirely in the refclk domain.
//
// Ports:
//   refclk      in   sole clock (PLL reference clock)
//   rst         in   synchronous, active-high reset
//   pll_locked  in   PLL locked flag, asynchronous to refclk
//   relock_req  in   single-cycle request for a full PLL re-sequence
//   pll_rst     out  PLL reset, high while holding the PLL in reset or failed
//   core_rst    out  reset for PLL-clocked logic, high in every state except running
//   ready       out  high only while running
//   fail        out  high only in the failed state
//   state_o     out  current state encoding (debug)
//   lost_count  out  saturating count of lock losses seen while running

module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 74250,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state_o,
  output logic [7:0] lost_count
);

  // State encodings are visible on state_o, so they are fixed values.
  localparam logic [2:0] StHold   = 3'd0;
  localparam logic [2:0] StWait   = 3'd1;
  localparam logic [2:0] StStable = 3'd2;
  localparam logic [2:0] StRun    = 3'd3;
  localparam logic [2:0] StFail   = 3'd4;

  localparam int unsigned RetryW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;

  localparam logic [CNT_W-1:0]  RstLast     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  StableLast  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryLast   = RetryW'(MAX_RETRIES - 1);

  localparam longint unsigned CntRange = 64'd1 << CNT_W;

  // Reject parameter sets the counters cannot represent.
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("pll_lock_sequencer: CNT_W must be in 1..32");
  end
  if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || MAX_RETRIES < 1)
  begin : g_bad_zero
    $error("pll_lock_sequencer: cycle and retry parameters must be at least 1");
  end
  if (longint'(RST_CYCLES) > CntRange || longint'(LOCK_TIMEOUT) > CntRange ||
      longint'(STABLE_CYCLES) > CntRange) begin : g_bad_range
    $error("pll_lock_sequencer: a cycle parameter exceeds 2**CNT_W");
  end

  logic              lk_meta_q, lk_s_q;
  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RetryW-1:0] retries_q, retries_d;
  logic [7:0]        lost_q, lost_d;

  // Two-flop synchronizer; every decision below uses lk_s_q only.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lk_meta_q <= 1'b0;
      lk_s_q    <= 1'b0;
    end else begin
      lk_meta_q <= pll_locked;
      lk_s_q    <= lk_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    lost_d    = lost_q;

    if (relock_req) begin
      // Overrides any transition this cycle, including a lock-loss count in RUN.
      state_d   = StHold;
      cnt_d     = '0;
      retries_d = '0;
    end else begin
      case (state_q)
        StHold: begin
          if (cnt_q == RstLast) begin
            state_d = StWait;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        StWait: begin
          if (lk_s_q) begin
            state_d = StStable;
            cnt_d   = '0;
          end else if (cnt_q == TimeoutLast) begin
            cnt_d = '0;
            if (retries_q == RetryLast) begin
              state_d = StFail;
            end else begin
              state_d   = StHold;
              retries_d = retries_q + RetryW'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        StStable: begin
          // A lock drop wins over completing the stable window on the same edge.
          if (!lk_s_q) begin
            state_d = StWait;
            cnt_d   = '0;
          end else if (cnt_q == StableLast) begin
            state_d   = StRun;
            cnt_d     = '0;
            retries_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        StRun: begin
          if (!lk_s_q) begin
            state_d = StHold;
            cnt_d   = '0;
            if (lost_q != 8'hFF) begin
              lost_d = lost_q + 8'd1;
            end
          end
        end

        StFail: begin
          // Parked until relock_req or rst.
        end

        default: begin
          state_d   = StHold;
          cnt_d     = '0;
          retries_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= StHold;
      cnt_q     <= '0;
      retries_q <= '0;
      lost_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      lost_q    <= lost_d;
    end
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    pll_rst    = (state_q == StHold) || (state_q == StFail);
    core_rst   = (state_q != StRun);
    ready      = (state_q == StRun);
    fail       = (state_q == StFail);
    state_o    = state_q;
    lost_count = lost_q;
  end

endmodule
